mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single backing-memory port between icache refill reads and dcache refill reads and writebacks.
- Sits between the two caches and main memory. One transaction is outstanding at a time; requests are line-sized bursts of BEATS beats.
- The caches hold hard_stall high while their request is pending. This block only arbitrates, sequences bursts and steers response beats to the owning cache.

Parameters:
- ADDR_W, 28, memory line-address width.
- DATA_W, 128, beat data width.
- BEATS, 4, beats per line; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_req_valid  in  1  icache read request
- ic_req_addr  in  ADDR_W  icache line address
- ic_req_ready  out  1  icache request granted this cycle
- ic_resp_valid  out  1  icache read beat valid
- ic_resp_data  out  DATA_W  icache read beat
- dc_req_valid  in  1  dcache request
- dc_req_rw  in  1  1 = write, 0 = read
- dc_req_addr  in  ADDR_W  dcache line address
- dc_req_ready  out  1  dcache request granted this cycle
- dc_wdata_valid  in  1  dcache write beat valid
- dc_wdata  in  DATA_W  dcache write beat
- dc_wdata_ready  out  1  write beat consumed
- dc_resp_valid  out  1  dcache read beat valid
- dc_resp_data  out  DATA_W  dcache read beat
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  1 = write
- mem_req_addr  out  ADDR_W  line address
- mem_wdata_valid  out  1  write beat valid
- mem_wdata_ready  in  1  memory accepts write beat
- mem_wdata  out  DATA_W  write beat
- mem_resp_valid  in  1  read beat valid
- mem_resp_data  in  DATA_W  read beat
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, REQ, WDATA, RDATA.
- Reset:
  - state = IDLE; owner = DC; beat counter = 0; mem_req_rw = 0; mem_req_addr = 0.
  - All valid/ready outputs are 0. busy = 0.
  - Reset mid-burst aborts the transaction; in-flight memory beats arriving later are ignored.
- IDLE:
  - Arbitrate among valid requests.
  - Grant is combinational: the winner's *_req_ready = 1 in the same cycle.
  - On grant, register owner, address and rw (icache rw = 0). Next state = REQ.
  - With no request, stay in IDLE.
- REQ:
  - mem_req_valid = 1, driven from registered addr and rw.
  - Stay until mem_req_ready = 1.
  - On handshake: rw = 1 goes to WDATA, rw = 0 goes to RDATA. Beat counter clears.
- WDATA:
  - mem_wdata_valid = dc_wdata_valid; mem_wdata = dc_wdata; dc_wdata_ready = mem_wdata_ready.
  - A beat transfers when both valid and ready are 1; the counter increments on each transfer.
  - After the transfer of beat BEATS-1, go to IDLE. Writes produce no response.
- RDATA:
  - Each mem_resp_valid beat is forwarded combinationally, same cycle, to the owner: ic_resp_* or dc_resp_*.
  - The other requester's resp_valid stays 0. Resp data outputs carry mem_resp_data regardless of owner.
  - The counter increments per beat. On beat BEATS-1, go to IDLE.
- Ignored inputs: mem_resp_valid is ignored in IDLE, REQ and WDATA. dc_wdata_valid is ignored outside WDATA.
- Request rules:
  - Requesters hold valid and addr stable until ready.
  - A grant is never issued outside IDLE, so there is exactly one IDLE cycle between transactions.
- Counter: width log2(BEATS); wraps to 0 on the last beat.
- Back-to-back: the same requester may be re-granted on the next IDLE cycle, subject to arbitration.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit last-grant register; reset value = DC, so IC wins the first tie.
  - On simultaneous requests in IDLE, the requester not granted last wins.
  - The register updates only on a grant.
- Undefined:
  - Fixed priority: dcache always wins a tie. The last-grant register is not built.
- A lone requester is always granted in both modes.

Test Plan:
- IC read alone, addr 0x0000123, memory ready immediately, 4 beats D0..D3 on consecutive cycles:
  - ic_req_ready in cycle 0; mem_req_valid in cycle 1 with addr 0x0000123, rw = 0.
  - ic_resp_valid on the 4 beat cycles with data D0..D3; dc_resp_valid stays 0; busy drops after beat 3.
- DC write, addr 0x00000AB, mem_wdata_ready toggling 1,0,1,1,0,1:
  - Exactly 4 beats transfer, in order, with dc_wdata_ready mirroring mem_wdata_ready.
  - Returns to IDLE after the 4th transfer; no resp_valid asserted.
- IC and DC request in the same cycle, repeated 3 times:
  - Fixed priority: DC, DC, DC.
  - MEM_ARB_ROUND_ROBIN_EN: IC, DC, IC.
- mem_req_ready held 0 for 5 cycles during REQ:
  - mem_req_valid and addr held stable throughout; no grant to the other requester, which is waiting.
- Reset asserted after beat 1 of a DC read:
  - Next cycle: IDLE, all outputs at reset values.
  - Stray mem_resp_valid beats that follow produce no resp_valid.
- Spurious mem_resp_valid = 1 in IDLE:
  - No ic_resp_valid or dc_resp_valid; state unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - icache, dcache and memory port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              ic_req_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_req_ready;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_ready;
    logic              dc_wdata_valid;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_wdata_ready;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              busy;

    // arbiter side
    modport master (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        output dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
        input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        output busy
    );

    // caches and memory side
    modport slave (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        input  dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
        output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache line-burst arbiter for one memory port; MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic OWN_DC = 1'b0;
    localparam logic OWN_IC = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    state_t            state, state_nxt;
    logic              owner_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pick_ic;
    logic              grant;
    logic              req_fire;
    logic              beat_fire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    // on a tie, the requester not served last time wins
    assign pick_ic = bus.ic_req_valid && (!bus.dc_req_valid || (last_grant_q == OWN_DC));
`else
    assign pick_ic = bus.ic_req_valid && !bus.dc_req_valid;
`endif

    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_wdata     = bus.dc_wdata;
    assign bus.ic_resp_data  = bus.mem_resp_data;
    assign bus.dc_resp_data  = bus.mem_resp_data;
    assign bus.busy          = (state != IDLE);

    always_comb begin
        state_nxt           = state;
        grant               = 1'b0;
        req_fire            = 1'b0;
        beat_fire           = 1'b0;
        bus.ic_req_ready    = 1'b0;
        bus.dc_req_ready    = 1'b0;
        bus.ic_resp_valid   = 1'b0;
        bus.dc_resp_valid   = 1'b0;
        bus.dc_wdata_ready  = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_wdata_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ic_req_valid || bus.dc_req_valid) begin
                    grant            = 1'b1;
                    bus.ic_req_ready = pick_ic;
                    bus.dc_req_ready = !pick_ic;
                    state_nxt        = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    req_fire  = 1'b1;
                    state_nxt = rw_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                bus.mem_wdata_valid = bus.dc_wdata_valid;
                bus.dc_wdata_ready  = bus.mem_wdata_ready;
                if (bus.dc_wdata_valid && bus.mem_wdata_ready) begin
                    beat_fire = 1'b1;
                    if (cnt_q == LAST_BEAT) state_nxt = IDLE;
                end
            end
            RDATA: begin
                if (bus.mem_resp_valid) begin
                    beat_fire         = 1'b1;
                    bus.ic_resp_valid = (owner_q == OWN_IC);
                    bus.dc_resp_valid = (owner_q == OWN_DC);
                    if (cnt_q == LAST_BEAT) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner_q <= OWN_DC;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_q <= pick_ic ? OWN_IC : OWN_DC;
                addr_q  <= pick_ic ? bus.ic_req_addr : bus.dc_req_addr;
                rw_q    <= pick_ic ? 1'b0 : bus.dc_req_rw;
            end
            if (req_fire) begin
                cnt_q <= '0;
            end else if (beat_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= OWN_DC;
        end else if (grant) begin
            last_grant_q <= pick_ic ? OWN_IC : OWN_DC;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter, fixed priority or MEM_ARB_ROUND_ROBIN_EN
module tb_mem_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;

    localparam logic [2:0] EV_GIC  = 3'd0;
    localparam logic [2:0] EV_GDC  = 3'd1;
    localparam logic [2:0] EV_MREQ = 3'd2;
    localparam logic [2:0] EV_WB   = 3'd3;
    localparam logic [2:0] EV_ICR  = 3'd4;
    localparam logic [2:0] EV_DCR  = 3'd5;

    typedef struct packed {
        logic [2:0]   kind;
        logic [127:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [127:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [2:0] kind, input logic [127:0] data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%0h expected none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.data !== data) begin
                bad++;
                $display("FAIL event: got kind=%0d data=%0h expected kind=%0d data=%0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ic_req_ready) observe(EV_GIC, 128'(bus.ic_req_addr));
            if (bus.dc_req_ready) observe(EV_GDC, 128'(bus.dc_req_addr));
            if (bus.mem_req_valid && bus.mem_req_ready)
                observe(EV_MREQ, 128'({bus.mem_req_rw, bus.mem_req_addr}));
            if (bus.mem_wdata_valid && bus.mem_wdata_ready) observe(EV_WB, bus.mem_wdata);
            if (bus.ic_resp_valid) observe(EV_ICR, bus.ic_resp_data);
            if (bus.dc_resp_valid) observe(EV_DCR, bus.dc_resp_data);
        end
    end

    task automatic idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
        chk({tag, "_valids"}, 128'({bus.ic_resp_valid, bus.dc_resp_valid, bus.mem_req_valid,
                                    bus.mem_wdata_valid, bus.dc_wdata_ready}), 128'd0);
        chk({tag, "_readies"}, 128'({bus.ic_req_ready, bus.dc_req_ready}), 128'd0);
        chk({tag, "_mem_req"}, 128'({bus.mem_req_rw, bus.mem_req_addr}), 128'd0);
    endtask

    task automatic beats(input bit to_ic, input logic [127:0] base);
        for (int i = 0; i < BEATS; i++) begin
            push(to_ic ? EV_ICR : EV_DCR, base + 128'(i));
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = base + 128'(i);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic run_read(input bit to_ic, input logic [ADDR_W-1:0] a,
                            input logic [127:0] base, input bit drop);
        push(to_ic ? EV_GIC : EV_GDC, 128'(a));
        tick();
        if (drop) begin
            if (to_ic) bus.ic_req_valid = 1'b0;
            else       bus.dc_req_valid = 1'b0;
        end
        push(EV_MREQ, 128'({1'b0, a}));
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        beats(to_ic, base);
    endtask

    initial begin
        logic [127:0] wd [4];
        bit           wr_rdy [6];
        bit           win [3];
        int           k;

        bus.ic_req_valid = 0; bus.ic_req_addr = '0;
        bus.dc_req_valid = 0; bus.dc_req_rw = 0; bus.dc_req_addr = '0;
        bus.dc_wdata_valid = 0; bus.dc_wdata = '0;
        bus.mem_req_ready = 0; bus.mem_wdata_ready = 0;
        bus.mem_resp_valid = 0; bus.mem_resp_data = '0;

        tick();
        tick();
        reset = 1'b0;
        idle_outputs("reset");

        // icache read alone
        tick();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 28'h0000123;
        run_read(1'b1, 28'h0000123, 128'hD000, 1'b1);
        @(negedge clk);
        chk("ic_read_busy_after", 128'(bus.busy), 128'd0);

        // dcache writeback with a stuttering memory
        tick();
        wd = '{128'hBEEF_0000, 128'hBEEF_0001, 128'hBEEF_0002, 128'hBEEF_0003};
        wr_rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b1;
        bus.dc_req_addr  = 28'h00000AB;
        push(EV_GDC, 128'h0AB);
        tick();
        bus.dc_req_valid = 1'b0;
        push(EV_MREQ, 128'({1'b1, 28'h00000AB}));
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            bus.dc_wdata_valid  = 1'b1;
            bus.dc_wdata        = wd[k];
            bus.mem_wdata_ready = wr_rdy[i];
            if (wr_rdy[i]) push(EV_WB, wd[k]);
            @(negedge clk);
            chk("wr_dc_wdata_ready", 128'(bus.dc_wdata_ready), 128'(wr_rdy[i]));
            chk("wr_mem_wdata_valid", 128'(bus.mem_wdata_valid), 128'd1);
            if (wr_rdy[i]) k++;
            tick();
        end
        bus.dc_wdata_valid  = 1'b0;
        bus.mem_wdata_ready = 1'b0;
        @(negedge clk);
        chk("wr_busy_after", 128'(bus.busy), 128'd0);

        // simultaneous requests, three in a row
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = '{1'b1, 1'b0, 1'b1};
`else
        win = '{1'b0, 1'b0, 1'b0};
`endif
        tick();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 28'h0000111;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b0;
        bus.dc_req_addr  = 28'h0000222;
        for (int r = 0; r < 3; r++)
            run_read(win[r], win[r] ? 28'h0000111 : 28'h0000222, 128'hA000 + 128'(r * 256), 1'b0);
        if (win[2]) bus.ic_req_valid = 1'b0;
        else        bus.dc_req_valid = 1'b0;
        run_read(!win[2], !win[2] ? 28'h0000111 : 28'h0000222, 128'hAF00, 1'b1);

        // memory stalls the request while icache waits
        tick();
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b0;
        bus.dc_req_addr  = 28'h00000CC;
        push(EV_GDC, 128'h0CC);
        tick();
        bus.dc_req_valid = 1'b0;
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 28'h00000DD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_mem_req_valid", 128'(bus.mem_req_valid), 128'd1);
            chk("stall_mem_req_addr", 128'(bus.mem_req_addr), 128'h0CC);
            chk("stall_ic_req_ready", 128'(bus.ic_req_ready), 128'd0);
            tick();
        end
        push(EV_MREQ, 128'h0CC);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        beats(1'b0, 128'hC000);
        run_read(1'b1, 28'h00000DD, 128'hDD00, 1'b1);

        // reset in the middle of a dcache read
        tick();
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b0;
        bus.dc_req_addr  = 28'h00000EE;
        push(EV_GDC, 128'h0EE);
        tick();
        bus.dc_req_valid = 1'b0;
        push(EV_MREQ, 128'h0EE);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(EV_DCR, 128'hE000 + 128'(i));
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 128'hE000 + 128'(i);
            tick();
        end
        reset = 1'b1;
        bus.mem_resp_data = 128'hE002;
        tick();
        reset = 1'b0;
        bus.mem_resp_valid = 1'b0;
        idle_outputs("mid_reset");
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 128'hE003 + 128'(i);
            @(negedge clk);
            chk("stray_resp_valid", 128'({bus.ic_resp_valid, bus.dc_resp_valid}), 128'd0);
            chk("stray_busy", 128'(bus.busy), 128'd0);
            tick();
        end
        bus.mem_resp_valid = 1'b0;

        // spurious memory beats while idle
        for (int i = 0; i < 3; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 128'h5500 + 128'(i);
            @(negedge clk);
            chk("idle_resp_valid", 128'({bus.ic_resp_valid, bus.dc_resp_valid}), 128'd0);
            chk("idle_busy", 128'(bus.busy), 128'd0);
            tick();
        end
        bus.mem_resp_valid = 1'b0;

        tick();
        tick();
        chk("scoreboard_left", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
